// File: rtl/float_div.sv
// Sequential IEEE-754 single-precision divider (vres = v1 / v2), restoring radix-2, fixed 28-cycle latency.
// Define FLOAT_DIV_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated toward zero.
module float_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] v1,
  input  logic [31:0] v2,
  output logic [31:0] vres,
  output logic        busy,
  output logic        done
);

  // Handshake: start is accepted only in IDLE outside the done cycle; busy is high
  // from the cycle after acceptance until done, and done is a one-cycle pulse with vres valid.
  typedef enum logic [1:0] {IDLE, DIV, RND, DONE} state_t;

  state_t              state;
  state_t              state_d;
  logic [4:0]          cnt;
  logic                sign;
  logic                spec_hit;
  logic [31:0]         spec_val;
  logic [23:0]         m2_q;
  logic [24:0]         r_q;
  logic [25:0]         q_q;
  logic signed [9:0]   e_q;
  logic [31:0]         res_q;

  logic                accept;
  logic [7:0]          e1;
  logic [7:0]          e2;
  logic                z1, z2, i1, i2, n1, n2;
  logic [23:0]         m1;
  logic [23:0]         m2;

  assign accept = (state == IDLE) && start && !done;

  assign e1 = v1[30:23];
  assign e2 = v2[30:23];
  assign z1 = (e1 == 8'd0);
  assign z2 = (e2 == 8'd0);
  assign i1 = (e1 == 8'hFF) && (v1[22:0] == 23'd0);
  assign i2 = (e2 == 8'hFF) && (v2[22:0] == 23'd0);
  assign n1 = (e1 == 8'hFF) && (v1[22:0] != 23'd0);
  assign n2 = (e2 == 8'hFF) && (v2[22:0] != 23'd0);
  assign m1 = {!z1, v1[22:0]};
  assign m2 = {!z2, v2[22:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = DIV;
      DIV:     if (cnt == 5'd25) state_d = RND;
      RND:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Normalisation and rounding of the finished quotient, consumed in RND.
  logic [23:0]       mant;
  logic              guard;
  logic              sticky;
  logic              round_inc;
  logic signed [9:0] e_n;
  logic signed [9:0] e_r;
  logic [24:0]       mant_sum;
  logic [23:0]       mant_r;
  logic [31:0]       rounded;

  always_comb begin
    if (q_q[25]) begin
      mant   = q_q[25:2];
      guard  = q_q[1];
      sticky = q_q[0] | (|r_q);
      e_n    = e_q;
    end else begin
      mant   = q_q[24:1];
      guard  = q_q[0];
      sticky = |r_q;
      e_n    = e_q - 10'sd1;
    end
  end

`ifdef FLOAT_DIV_RNE_EN
  assign round_inc = guard & (sticky | mant[0]);
`else
  logic unused_round_bits;
  assign unused_round_bits = guard ^ sticky;
  assign round_inc = 1'b0;
`endif

  always_comb begin
    mant_sum = {1'b0, mant} + {24'd0, round_inc};
    mant_r   = mant_sum[23:0];
    e_r      = e_n;
    if (mant_sum[24]) begin
      mant_r = 24'h800000;
      e_r    = e_n + 10'sd1;
    end
    if (e_r >= 10'sd255)    rounded = {sign, 8'hFF, 23'd0};
    else if (e_r <= 10'sd0) rounded = {sign, 31'd0};
    else                    rounded = {sign, e_r[7:0], mant_r[22:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 5'd0;
      sign     <= 1'b0;
      spec_hit <= 1'b0;
      spec_val <= 32'd0;
      m2_q     <= 24'd0;
      r_q      <= 25'd0;
      q_q      <= 26'd0;
      e_q      <= 10'sd0;
      res_q    <= 32'd0;
      vres     <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sign <= v1[31] ^ v2[31];
            m2_q <= m2;
            r_q  <= {1'b0, m1};
            q_q  <= 26'd0;
            cnt  <= 5'd0;
            e_q  <= signed'({2'b00, e1}) - signed'({2'b00, e2}) + 10'sd127;
            busy <= 1'b1;
            // Specials are decided now; the divider still runs for constant latency.
            if (n1 || n2 || (z1 && z2) || (i1 && i2)) begin
              spec_hit <= 1'b1;
              spec_val <= 32'h7FC00000;
            end else if ((!z1 && z2) || (i1 && !i2)) begin
              spec_hit <= 1'b1;
              spec_val <= {v1[31] ^ v2[31], 8'hFF, 23'd0};
            end else if (z1 || i2) begin
              spec_hit <= 1'b1;
              spec_val <= {v1[31] ^ v2[31], 31'd0};
            end else begin
              spec_hit <= 1'b0;
              spec_val <= 32'd0;
            end
          end
        end
        DIV: begin
          if (r_q >= {1'b0, m2_q}) begin
            r_q <= (r_q - {1'b0, m2_q}) << 1;
            q_q <= {q_q[24:0], 1'b1};
          end else begin
            r_q <= r_q << 1;
            q_q <= {q_q[24:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
        end
        RND: begin
          res_q <= spec_hit ? spec_val : rounded;
        end
        DONE: begin
          vres <= res_q;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_div.sv
// Directed bench for float_div: result values, 28-cycle latency, busy window, ignored starts, async reset abort.
module tb_float_div;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] v1;
  logic [31:0] v2;
  logic [31:0] vres;
  logic        busy;
  logic        done;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q[$];

  float_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .v1    (v1),
    .v2    (v2),
    .vres  (vres),
    .busy  (busy),
    .done  (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Launch one division and follow it to done; poke >= 0 re-pulses start mid-DIV with other operands.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int poke);
    int          cyc;
    int          nbusy;
    logic [31:0] want;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b1;
    v1    = a;
    v2    = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    v1    = $urandom;
    v2    = $urandom;
    cyc   = 0;
    nbusy = 0;
    while (!done && cyc < 40) begin
      if (busy) nbusy++;
      if (cyc == poke) begin
        start = 1'b1;
        v1    = 32'h3F800000;
        v2    = 32'h40000000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    want  = exp_q.pop_front();
    check($sformatf("%s_latency", tag), 32'(cyc), 32'd28);
    check($sformatf("%s_busy_cycles", tag), 32'(nbusy), 32'd28);
    check($sformatf("%s_busy_in_done", tag), {31'd0, busy}, 32'd0);
    check($sformatf("%s_vres", tag), vres, want);
    // start in the done cycle must not be accepted
    start = 1'b1;
    v1    = a;
    v2    = b;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("%s_done_pulse", tag), {31'd0, done}, 32'd0);
    check($sformatf("%s_no_accept_in_done", tag), {31'd0, busy}, 32'd0);
    check($sformatf("%s_vres_held", tag), vres, want);
  endtask

  initial begin
    int nd;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    v1       = 32'd0;
    v2       = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_vres", vres, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("div_7p25_0p5", 32'h40E80000, 32'h3F000000, 32'h41680000, -1);
`ifdef FLOAT_DIV_RNE_EN
    run_op("div_1_3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, -1);
`else
    run_op("div_1_3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, -1);
`endif
    run_op("div_m6_2",     32'hC0C00000, 32'h40000000, 32'hC0400000, -1);
    run_op("div_9_3",      32'h41100000, 32'h40400000, 32'h40400000, -1);
    run_op("div_2_m4",     32'h40000000, 32'hC0800000, 32'hBF000000, -1);
    run_op("div_1_0",      32'h3F800000, 32'h00000000, 32'h7F800000, -1);
    run_op("div_m1_0",     32'hBF800000, 32'h00000000, 32'hFF800000, -1);
    run_op("div_0_0",      32'h00000000, 32'h00000000, 32'h7FC00000, -1);
    run_op("div_0_2",      32'h00000000, 32'h40000000, 32'h00000000, -1);
    run_op("div_nan_2",    32'hFFC00001, 32'h40000000, 32'h7FC00000, -1);
    run_op("div_inf_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, -1);
    run_op("div_inf_m2",   32'h7F800000, 32'hC0000000, 32'hFF800000, -1);
    run_op("div_3_inf",    32'h40400000, 32'h7F800000, 32'h00000000, -1);
    run_op("overflow",     32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, -1);
    run_op("underflow",    32'h00800000, 32'h40000000, 32'h00000000, -1);
    run_op("start_mid_div", 32'hC0C00000, 32'h40000000, 32'hC0400000, 5);

    // Asynchronous reset 10 cycles into an operation aborts it with no done.
    @(negedge clk);
    start = 1'b1;
    v1    = 32'h40E80000;
    v2    = 32'h3F000000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_vres", vres, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);
    run_op("after_abort", 32'h40E80000, 32'h3F000000, 32'h41680000, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
